vx_dispatch_rr_arb: RTL and testbench

- Shares one downstream execution-unit dispatch port among NUM_REQS upstream dispatch requesters, e.g. issue slots feeding a single shared SFU.
- Each requester presents a valid/ready/data stream. The block grants one requester per cycle using round-robin priority.
- The winning payload and its requester index are registered into a 2-entry elastic output stage.
- The block keeps saturating per-requester stall counters for performance reporting.

---
 rtl/vx_dispatch_rr_arb.sv | 130 +++++++++++++
 tb/tb_vx_dispatch_rr_arb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_rr_arb.sv
// Round-robin dispatch arbiter: NUM_REQS valid/ready requesters share one
// downstream port through a 2-entry registered elastic buffer, with
// saturating per-requester stall counters for performance reporting.
module vx_dispatch_rr_arb #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64,
  parameter int REQ_SELW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int PERF_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [NUM_REQS-1:0]        i_in_valid,
  input  logic [NUM_REQS*DATAW-1:0]  i_in_data,
  output logic [NUM_REQS-1:0]        o_in_ready,
  output logic                       o_out_valid,
  output logic [DATAW-1:0]           o_out_data,
  output logic [REQ_SELW-1:0]        o_out_sel,
  input  logic                       i_out_ready,
  output logic [NUM_REQS*PERF_W-1:0] o_perf_stalls
);

  logic [REQ_SELW-1:0] r_last_grant;
  logic [1:0]          r_count;
  logic [REQ_SELW-1:0] r_sel0, r_sel1;
  logic [DATAW-1:0]    r_data0, r_data1;

  logic [NUM_REQS-1:0] w_grant;
  logic [REQ_SELW-1:0] w_win_idx;
  logic [REQ_SELW-1:0] w_cand;
  logic                w_any;
  logic                w_can_accept;
  logic                w_push;
  logic                w_pop;
  logic [DATAW-1:0]    w_push_data;

  function automatic logic [REQ_SELW-1:0] wrap_idx(input int v);
    int r;
    r = v % NUM_REQS;
    return REQ_SELW'(r);
  endfunction

  // Round-robin search starting just after the last requester that fired.
  always_comb begin
    w_grant   = '0;
    w_win_idx = '0;
    w_cand    = '0;
    w_any     = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      w_cand = wrap_idx(int'(r_last_grant) + 1 + k);
      if (!w_any && i_in_valid[w_cand]) begin
        w_any     = 1'b1;
        w_win_idx = w_cand;
      end
    end
    if (w_any) w_grant[w_win_idx] = 1'b1;
  end

  // Acceptance depends only on registered occupancy, never on i_out_ready.
  assign w_can_accept = (r_count != 2'd2);
  assign o_in_ready   = w_grant & {NUM_REQS{w_can_accept}};
  assign w_push       = |o_in_ready;
  assign w_pop        = o_out_valid & i_out_ready;
  assign w_push_data  = i_in_data[w_win_idx*DATAW +: DATAW];

  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = r_data0;
  assign o_out_sel   = r_sel0;

  // Priority pointer moves only when a requester actually transfers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last_grant <= REQ_SELW'(NUM_REQS - 1);
    end else if (w_push) begin
      r_last_grant <= w_win_idx;
    end
  end

  // Buffer occupancy; a push at full occupancy is blocked by w_can_accept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 2'd0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer payload: entry 0 is always the head, entry 1 the spill slot.
  always_ff @(posedge i_clk) begin
    if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
      r_data0 <= w_push_data;
      r_sel0  <= w_win_idx;
    end else if (w_pop) begin
      r_data0 <= r_data1;
      r_sel0  <= r_sel1;
    end
    if (w_push && (r_count == 2'd1) && !w_pop) begin
      r_data1 <= w_push_data;
      r_sel1  <= w_win_idx;
    end
  end

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_stall
    logic [PERF_W-1:0] r_cnt;

    // Count cycles a requester waits, whether it lost arbitration or the buffer was full.
    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        r_cnt <= '0;
      end else if (i_in_valid[g] && !o_in_ready[g] && (r_cnt != {PERF_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign o_perf_stalls[g*PERF_W +: PERF_W] = r_cnt;
  end

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_reset)
    $onehot0(o_in_ready));
  a_no_push_full: assert property (@(posedge i_clk) disable iff (i_reset)
    w_push |-> (r_count != 2'd2));
  a_out_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (o_out_valid && !i_out_ready) |=> ($stable(o_out_data) && $stable(o_out_sel)));
`endif

endmodule

// File: tb/tb_vx_dispatch_rr_arb.sv
// Directed and model-checked bench for the round-robin dispatch arbiter.
module tb_vx_dispatch_rr_arb;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int PW = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  logic [N*PW-1:0] perf;

  int n_cmp = 0;
  int n_bad = 0;

  vx_dispatch_rr_arb #(.NUM_REQS(N), .DATAW(DW), .PERF_W(PW)) u_dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_in_valid    (in_valid),
    .i_in_data     (in_data),
    .o_in_ready    (in_ready),
    .o_out_valid   (out_valid),
    .o_out_data    (out_data),
    .o_out_sel     (out_sel),
    .i_out_ready   (out_ready),
    .o_perf_stalls (perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = '0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
  endtask

  task automatic fixed_data();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 64'hA0 + 64'(i);
  endtask

  function automatic logic [PW-1:0] perf_of(input int i);
    return perf[i*PW +: PW];
  endfunction

  logic [65:0] q[$];
  int          m_count;
  int          m_last;
  int          win;
  logic [3:0]  exp_rdy;

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;

    // reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_perf", 64'(perf), 64'd0);
    chk("rst_in_ready_idle", 64'(in_ready), 64'd0);

    // fairness: all valid, sink always ready
    fixed_data();
    out_ready = 1'b1;
    in_valid  = 4'hF;
    #1;
    for (int k = 0; k < 8; k++) begin
      chk("fair_in_ready", 64'(in_ready), 64'(1 << (k % 4)));
      step();
      chk("fair_out_valid", 64'(out_valid), 64'd1);
      chk("fair_out_sel", 64'(out_sel), 64'(k % 4));
      chk("fair_out_data", out_data, 64'hA0 + 64'(k % 4));
    end
    do_reset();

    // sparse: only 1 and 3 requesting
    in_valid = 4'b1010;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("sparse_in_ready", 64'(in_ready), (k % 2) ? 64'h8 : 64'h2);
      step();
      chk("sparse_out_sel", 64'(out_sel), (k % 2) ? 64'd3 : 64'd1);
    end
    chk("sparse_perf0", 64'(perf_of(0)), 64'd0);
    chk("sparse_perf2", 64'(perf_of(2)), 64'd0);
    chk("sparse_perf1", 64'(perf_of(1)), 64'd2);
    chk("sparse_perf3", 64'(perf_of(3)), 64'd2);
    do_reset();

    // backpressure: sink stalled, everyone requesting
    out_ready = 1'b0;
    in_valid  = 4'hF;
    #1;
    chk("bp_in_ready_c1", 64'(in_ready), 64'h1);
    step();
    chk("bp_in_ready_c2", 64'(in_ready), 64'h2);
    chk("bp_sel_c2", 64'(out_sel), 64'd0);
    step();
    for (int k = 3; k <= 5; k++) begin
      chk("bp_in_ready_full", 64'(in_ready), 64'h0);
      chk("bp_hold_sel", 64'(out_sel), 64'd0);
      chk("bp_hold_data", out_data, 64'hA0);
      step();
    end
    chk("bp_perf0", 64'(perf_of(0)), 64'd4);
    chk("bp_perf1", 64'(perf_of(1)), 64'd4);
    chk("bp_perf2", 64'(perf_of(2)), 64'd5);
    chk("bp_perf3", 64'(perf_of(3)), 64'd5);
    out_ready = 1'b1;
    #1;
    chk("bp_drain_ready", 64'(in_ready), 64'h0);
    chk("bp_drain_sel0", 64'(out_sel), 64'd0);
    step();
    chk("bp_drain_sel1", 64'(out_sel), 64'd1);
    chk("bp_resume_ready", 64'(in_ready), 64'h4);
    step();
    chk("bp_resume_sel", 64'(out_sel), 64'd2);
    chk("bp_resume_data", out_data, 64'hA2);
    do_reset();

    // stability: random valid, payloads and backpressure against a reference model
    m_count = 0;
    m_last  = 3;
    for (int c = 0; c < 60; c++) begin
      in_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      #1;
      win = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_last + 1 + k) % N;
        if (win < 0 && in_valid[j]) win = j;
      end
      exp_rdy = (win >= 0 && m_count < 2) ? 4'(1 << win) : 4'h0;
      chk("stab_in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("stab_out_valid", 64'(out_valid), 64'(m_count != 0));
      if (m_count != 0) begin
        chk("stab_out_sel", 64'(out_sel), 64'(q[0][65:64]));
        chk("stab_out_data", out_data, q[0][63:0]);
        if (out_ready) begin
          void'(q.pop_front());
          m_count--;
        end
      end
      if (exp_rdy != 4'h0) begin
        q.push_back({2'(win), in_data[win*DW +: DW]});
        m_count++;
        m_last = win;
      end
      step();
    end
    q.delete();
    do_reset();

    // saturation: requester 2 held with sink stalled
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int k = 0; k < 10; k++) step();
    chk("sat_perf2_mid", 64'(perf_of(2)), 64'd8);
    for (int k = 0; k < 10; k++) step();
    chk("sat_perf2_top", 64'(perf_of(2)), 64'd15);
    step();
    step();
    chk("sat_perf2_hold", 64'(perf_of(2)), 64'd15);
    chk("sat_perf0", 64'(perf_of(0)), 64'd0);

    // mid-operation reset with a full buffer
    chk("mid_pre_valid", 64'(out_valid), 64'd1);
    chk("mid_pre_ready", 64'(in_ready), 64'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_out_valid", 64'(out_valid), 64'd0);
    chk("mid_perf", 64'(perf), 64'd0);
    in_valid = 4'hF;
    #1;
    chk("mid_first_grant", 64'(in_ready), 64'h1);
    step();
    chk("mid_first_sel", 64'(out_sel), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
